// File: rtl/mc_pkg.sv
// Shared types and constants for the MC feed sequencer: beat counts,
// FSM state encoding, the beat record carried through the skid FIFO,
// and the beat-index to buffer-address mapping.
package mc_pkg;
    localparam int WORD_W          = 32;
    localparam int MB_LUMA_BEATS   = 64;
    localparam int MB_CHROMA_BEATS = 32;
    localparam int MB_BEATS        = MB_LUMA_BEATS + MB_CHROMA_BEATS;
    localparam int CHROMA_BASE     = 64;
    localparam int CR_OFFSET       = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LUMA,
        ST_CHROMA,
        ST_DRAIN
    } fsm_state_e;

    typedef struct packed {
        logic              ccin;
        logic [WORD_W-1:0] cur_w;
        logic [WORD_W-1:0] ref_w;
    } beat_t;

    // Beat k: block = k[6:2], row = k[1:0].
    // Luma: 4x4 grid of blocks, word rows of 4 words each -> {blk_y, row, blk_x}.
    // Chroma: Cb at CHROMA_BASE, Cr at +CR_OFFSET, each a 2x2 grid of blocks.
    function automatic logic [6:0] beat_addr(input logic [6:0] k);
        logic [6:0] a;
        if (!k[6]) begin
            a = {1'b0, k[5:4], k[1:0], k[3:2]};
        end else begin
            a = 7'(CHROMA_BASE) + (k[4] ? 7'(CR_OFFSET) : 7'd0)
              + {3'b000, k[3], k[1:0], k[2]};
        end
        return a;
    endfunction
endpackage

// File: rtl/mc_feed_sched_if.sv
// Buffer read ports and the valid/ready beat port toward mc.
// master = sequencer side, slave = buffers plus mc side.
interface mc_feed_sched_if #(
    parameter int ADDR_W = 7,
    parameter int WORD_W = 32
);
    logic              cur_rd_en;
    logic [ADDR_W-1:0] cur_rd_addr;
    logic [WORD_W-1:0] cur_rd_data;
    logic              ref_rd_en;
    logic [ADDR_W-1:0] ref_rd_addr;
    logic [WORD_W-1:0] ref_rd_data;
    logic              src_valid;
    logic              src_ready;
    logic [WORD_W-1:0] curr_mb;
    logic [WORD_W-1:0] ref_frame;
    logic              ccin;

    modport master (
        output cur_rd_en, cur_rd_addr, ref_rd_en, ref_rd_addr,
        input  cur_rd_data, ref_rd_data,
        output src_valid, curr_mb, ref_frame, ccin,
        input  src_ready
    );

    modport slave (
        input  cur_rd_en, cur_rd_addr, ref_rd_en, ref_rd_addr,
        output cur_rd_data, ref_rd_data,
        input  src_valid, curr_mb, ref_frame, ccin,
        output src_ready
    );
endinterface

// File: rtl/mc_skid_fifo.sv
// Two-entry valid/ready FIFO; head entry drives the outputs directly so
// they stay stable while the consumer stalls.
module mc_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push, pop;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = cnt_q;
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && ((cnt_q != 2'd2) || pop);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // State registers; reset empties the FIFO and zeroes the head outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/mc_feed_sched.sv
// Per-macroblock feed sequencer for the inter MC datapath.
// Reads 64 luma + 32 chroma word pairs from the cur/ref buffers and streams
// them to mc through a 2-entry skid FIFO.
// Optional build macro MC_FEED_STALL_CNT_EN adds the stall_cnt output.
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_LUMA   | issuing luma reads, beats 0..63
// ST_CHROMA | issuing chroma reads, beats 64..95
// ST_DRAIN  | all reads issued, emptying FIFO; done on last accept
module mc_feed_sched
    import mc_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int MB_SIZE     = 4,
    parameter int ADDR_W      = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
`ifdef MC_FEED_STALL_CNT_EN
    output logic [15:0]     stall_cnt,
`endif
    mc_feed_sched_if.master bus
);
    localparam int WORD_W_L = PIXEL_WIDTH * MB_SIZE;

    fsm_state_e state_q, state_d;
    logic       busy_q, busy_d;
    logic [6:0] rd_cnt_q, rd_cnt_d;
    logic       infl_q, infl_d;
    logic       tag_q, tag_d;
    logic [1:0] fifo_cnt;
    logic [2:0] occ;
    logic       src_valid, pop, active, rd_en, done_w;
    beat_t      push_beat, head;

    // Reads are credited against entries that will still be held after this
    // cycle's pop, which keeps one beat per cycle without ever overfilling.
    assign pop    = src_valid && bus.src_ready;
    assign occ    = {1'b0, fifo_cnt} + {2'b00, infl_q} - {2'b00, pop};
    assign active = (state_q == ST_LUMA) || (state_q == ST_CHROMA);
    assign rd_en  = active && (occ < 3'd2);
    assign done_w = (state_q == ST_DRAIN) && !infl_q && (fifo_cnt == 2'd1) && pop;

    assign bus.cur_rd_en   = rd_en;
    assign bus.ref_rd_en   = rd_en;
    assign bus.cur_rd_addr = ADDR_W'(beat_addr(rd_cnt_q));
    assign bus.ref_rd_addr = ADDR_W'(beat_addr(rd_cnt_q));
    assign bus.src_valid   = src_valid;
    assign bus.curr_mb     = WORD_W_L'(head.cur_w);
    assign bus.ref_frame   = WORD_W_L'(head.ref_w);
    assign bus.ccin        = head.ccin;
    assign busy            = busy_q;
    assign done            = done_w;

    // Returned buffer words tagged with the luma/chroma flag of their read.
    always_comb begin
        push_beat.ccin  = tag_q;
        push_beat.cur_w = bus.cur_rd_data;
        push_beat.ref_w = bus.ref_rd_data;
    end

    mc_skid_fifo #(.W($bits(beat_t))) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (infl_q),
        .in_data   (push_beat),
        .out_valid (src_valid),
        .out_ready (bus.src_ready),
        .out_data  (head),
        .count     (fifo_cnt)
    );

    // FSM next-state and read-beat counter.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        rd_cnt_d = rd_cnt_q;
        infl_d   = rd_en;
        tag_d    = rd_cnt_q[6];
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LUMA;
                    busy_d   = 1'b1;
                    rd_cnt_d = 7'd0;
                end
            end
            ST_LUMA: begin
                if (rd_en) begin
                    rd_cnt_d = rd_cnt_q + 7'd1;
                    if (rd_cnt_q == 7'(MB_LUMA_BEATS - 1)) state_d = ST_CHROMA;
                end
            end
            ST_CHROMA: begin
                if (rd_en) begin
                    if (rd_cnt_q == 7'(MB_BEATS - 1)) begin
                        state_d  = ST_DRAIN;
                        rd_cnt_d = 7'd0;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 7'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (done_w) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and read-tracking registers; reset aborts any MB in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            rd_cnt_q <= 7'd0;
            infl_q   <= 1'b0;
            tag_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            rd_cnt_q <= rd_cnt_d;
            infl_q   <= infl_d;
            tag_q    <= tag_d;
        end
    end

`ifdef MC_FEED_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of stalled cycles within the current MB.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) && start) begin
            stall_d = 16'd0;
        end else if (src_valid && !bus.src_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_q <= 16'd0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_mc_feed_sched.sv
// Self-checking bench for mc_feed_sched: directed MB runs with constant,
// random and boundary-stalled src_ready against an address/data model.
module tb_mc_feed_sched;
    logic clk;
    logic reset;
    logic start;
    logic busy;
    logic done;
`ifdef MC_FEED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] cur_mem [128];
    logic [31:0] ref_mem [128];

    mc_feed_sched_if #(.ADDR_W(7), .WORD_W(32)) bus ();

    mc_feed_sched #(.PIXEL_WIDTH(8), .MB_SIZE(4), .ADDR_W(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
`ifdef MC_FEED_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency word buffers.
    always @(posedge clk) begin
        if (bus.cur_rd_en) bus.cur_rd_data <= cur_mem[bus.cur_rd_addr];
        if (bus.ref_rd_en) bus.ref_rd_data <= ref_mem[bus.ref_rd_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Word address of beat k, straight from the block/row layout.
    function automatic int model_addr(input int k);
        int blk, r, c;
        blk = k / 4;
        r   = k % 4;
        if (blk < 16) return ((blk / 4) * 4 + r) * 4 + (blk % 4);
        c = blk - 16;
        return 64 + (c / 4) * 16 + (((c % 4) / 2) * 4 + r) * 2 + (c % 2);
    endfunction

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_cur_rd_en"}, bus.cur_rd_en, 0);
        chk({pfx, "_ref_rd_en"}, bus.ref_rd_en, 0);
        chk({pfx, "_cur_addr"}, bus.cur_rd_addr, 0);
        chk({pfx, "_ref_addr"}, bus.ref_rd_addr, 0);
        chk({pfx, "_src_valid"}, bus.src_valid, 0);
        chk({pfx, "_curr_mb"}, bus.curr_mb, 0);
        chk({pfx, "_ref_frame"}, bus.ref_frame, 0);
        chk({pfx, "_ccin"}, bus.ccin, 0);
`ifdef MC_FEED_STALL_CNT_EN
        chk({pfx, "_stall_cnt"}, stall_cnt, 0);
`endif
    endtask

    // Runs one MB. Cycle 0 is the first cycle with busy high.
    task automatic run_mb(input bit random_ready, input int stall_beat, input int stall_len,
                          input bit pre_started, input bit tricks, input bit hold_next,
                          input int exp_done_cyc, input int exp_stalls);
        int beat = 0, issued = 0, popped = 0, done_cyc = -1, n_done = 0;
        int stalls = 0, stall_used = 0;
        bit pulsed30 = 0, prev_hold = 0, rdy, popped_now;
        logic [31:0] prev_cur = '0, prev_ref = '0;
        logic prev_cc = 1'b0;
        if (!pre_started) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (done_cyc >= 0) begin
                start         = hold_next;
                bus.src_ready = 1'b1;
                #1;
                chk("busy_after_done", busy, 0);
                chk("done_single", done, 0);
                chk("valid_after_done", bus.src_valid, 0);
                break;
            end
            start = 1'b0;
            if (random_ready) rdy = ($urandom_range(0, 1) == 1);
            else if (beat == stall_beat && stall_used < stall_len) begin
                rdy = 1'b0;
                stall_used++;
            end else rdy = 1'b1;
            bus.src_ready = rdy;
            #1;
            chk("busy", busy, 1);
            chk("rd_en_pair", bus.ref_rd_en, bus.cur_rd_en);
            if (bus.cur_rd_en) begin
                chk("cur_rd_addr", bus.cur_rd_addr, model_addr(issued));
                chk("ref_rd_addr", bus.ref_rd_addr, model_addr(issued));
                issued++;
            end
            popped_now = 1'b0;
            if (bus.src_valid) begin
                if (beat == 0) chk("first_valid_cycle", cyc, 2);
                if (prev_hold) begin
                    chk("hold_curr_mb", bus.curr_mb, prev_cur);
                    chk("hold_ref_frame", bus.ref_frame, prev_ref);
                    chk("hold_ccin", bus.ccin, prev_cc);
                end
                chk("beat_ccin", bus.ccin, (beat >= 64));
                chk("beat_curr_mb", bus.curr_mb, cur_mem[model_addr(beat)]);
                chk("beat_ref_frame", bus.ref_frame, ref_mem[model_addr(beat)]);
                prev_cur = bus.curr_mb;
                prev_ref = bus.ref_frame;
                prev_cc  = bus.ccin;
                if (rdy) begin
                    popped++;
                    beat++;
                    popped_now = 1'b1;
                end else stalls++;
                prev_hold = !rdy;
            end else prev_hold = 1'b0;
            chk("outstanding_le_2", ((issued - popped) <= 2), 1);
            chk("issued_le_96", (issued <= 96), 1);
            chk("done", done, (popped_now && beat == 96));
            if (done) begin
                done_cyc = cyc;
                n_done++;
            end
            if (tricks && beat == 30 && !pulsed30) begin
                start    = 1'b1;
                pulsed30 = 1'b1;
            end
            if (tricks && done) start = 1'b1;
        end
        chk("done_seen", (done_cyc >= 0), 1);
        chk("done_count", n_done, 1);
        chk("beats_total", beat, 96);
        if (exp_done_cyc >= 0) chk("done_cycle", done_cyc, exp_done_cyc);
`ifdef MC_FEED_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, (exp_stalls >= 0) ? exp_stalls : stalls);
`else
        if (exp_stalls >= 0 && !random_ready) chk("stall_cycles_seen", stalls, exp_stalls);
`endif
    endtask

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        bus.src_ready = 1'b0;
        for (int a = 0; a < 128; a++) begin
            cur_mem[a] = 32'(a);
            ref_mem[a] = 32'(a) + 32'h0000_1000;
        end
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Streaming, word = address pattern, no backpressure.
        run_mb(1'b0, -1, 0, 1'b0, 1'b0, 1'b0, 97, 0);

        // Random buffer contents with 50% backpressure.
        for (int a = 0; a < 128; a++) begin
            cur_mem[a] = $urandom;
            ref_mem[a] = $urandom;
        end
        run_mb(1'b1, -1, 0, 1'b0, 1'b0, 1'b0, -1, -1);

        // Ten-cycle stall with beat 63 at the head, beat 64 queued behind it.
        run_mb(1'b0, 63, 10, 1'b0, 1'b0, 1'b0, 107, 10);

        // Starts at beat 30 and in the done cycle are ignored.
        run_mb(1'b0, -1, 0, 1'b0, 1'b1, 1'b0, 97, 0);
        // Same, but start held one cycle past done launches the next MB.
        run_mb(1'b0, -1, 0, 1'b0, 1'b1, 1'b1, 97, 0);
        run_mb(1'b1, -1, 0, 1'b1, 1'b0, 1'b0, -1, -1);

        // Asynchronous reset mid-LUMA, applied away from any clock edge.
        @(negedge clk);
        start         = 1'b1;
        bus.src_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_luma_reset");
        @(negedge clk);
        check_reset_outputs("held_reset");
        reset = 1'b1;
        @(negedge clk);
        run_mb(1'b0, -1, 0, 1'b0, 1'b0, 1'b0, 97, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
